// File: rtl/demux_sel_gen_pkg.sv
// Shared definitions for the demux select generator: width helpers,
// counting-mode constants and the packed-slice index helper.
package demux_sel_pkg;

  // Counting modes for the per-channel select counter
  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Select width: at least one bit even for tiny depths
  function automatic int sel_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Low bit index of channel idx inside a packed per-channel vector
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/demux_sel_gen_if.sv
// Bus bundle between the buffer control logic and the select generator.
interface demux_sel_gen_if #(
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = 2,
  parameter int ROUND_W = 4
);
  logic [NUM_CH-1:0]         buff_use;
  logic [NUM_CH-1:0]         ch_clr;
  logic [NUM_CH*SEL_W-1:0]   custom_demux_sel;
  logic [NUM_CH-1:0]         wrap_pulse;
  logic [NUM_CH-1:0]         sat_flag;
  logic [NUM_CH*ROUND_W-1:0] round_cnt;
  logic                      all_done;

  // Buffer control side: drives strobes, observes selects and status
  modport master (
    output buff_use, ch_clr,
    input  custom_demux_sel, wrap_pulse, sat_flag, round_cnt, all_done
  );

  // Generator side
  modport slave (
    input  buff_use, ch_clr,
    output custom_demux_sel, wrap_pulse, sat_flag, round_cnt, all_done
  );
endinterface

// File: rtl/demux_sel_gen_chan.sv
// Single-channel select counter: wraps or saturates at DEPTH-1, counts
// completed rounds (saturating) and emits a one-cycle wrap pulse.
module demux_sel_chan
  import demux_sel_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WRAP_MODE = MODE_WRAP,
  parameter int ROUND_W   = 4,
  parameter int SEL_W     = sel_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               buff_use,
  input  logic               ch_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               wrap_pulse,
  output logic               sat_flag,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               done
);

  localparam logic [SEL_W-1:0]   LAST      = SEL_W'(DEPTH - 1);
  localparam logic [ROUND_W-1:0] ROUND_MAX = '1;
  localparam bit                 IS_WRAP   = (WRAP_MODE == MODE_WRAP);

  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [ROUND_W-1:0] round_reg, round_next;
  logic               pulse_reg, pulse_next;
  logic               sat_reg, sat_next;

  // Next-state: clear beats advance; out-of-range encodings recover to 0
  always_comb begin
    sel_next   = sel_reg;
    round_next = round_reg;
    pulse_next = 1'b0;
    sat_next   = 1'b0;
    if (ch_clr) begin
      sel_next   = '0;
      round_next = '0;
    end else begin
      // sat_flag follows the select register one cycle late
      sat_next = !IS_WRAP && (sel_reg == LAST);
      if (buff_use) begin
        if (sel_reg == LAST) begin
          if (IS_WRAP) begin
            sel_next   = '0;
            pulse_next = 1'b1;
            if (round_reg != ROUND_MAX) round_next = round_reg + ROUND_W'(1);
          end
        end else if (sel_reg < LAST) begin
          sel_next = sel_reg + SEL_W'(1);
        end else begin
          sel_next = '0;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg   <= '0;
      round_reg <= '0;
      pulse_reg <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      sel_reg   <= sel_next;
      round_reg <= round_next;
      pulse_reg <= pulse_next;
      sat_reg   <= sat_next;
    end
  end

  assign sel        = sel_reg;
  assign wrap_pulse = pulse_reg;
  assign sat_flag   = sat_reg;
  assign round_cnt  = round_reg;
  assign done       = IS_WRAP ? (round_reg != '0) : sat_reg;

endmodule

// File: rtl/demux_sel_gen.sv
// Multi-channel demux select generator: NUM_CH independent counters,
// packed outputs and a registered all-channels-done flag.
module demux_sel_gen
  import demux_sel_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 4,
  parameter int WRAP_MODE = MODE_WRAP,
  parameter int ROUND_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  demux_sel_gen_if.slave bus
);

  localparam int SEL_W = sel_width(DEPTH);

  logic [NUM_CH-1:0] done;
  logic              all_done_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic [SEL_W-1:0]   sel_w;
      logic [ROUND_W-1:0] round_w;

      demux_sel_chan #(
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE),
        .ROUND_W   (ROUND_W),
        .SEL_W     (SEL_W)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .buff_use   (bus.buff_use[gi]),
        .ch_clr     (bus.ch_clr[gi]),
        .sel        (sel_w),
        .wrap_pulse (bus.wrap_pulse[gi]),
        .sat_flag   (bus.sat_flag[gi]),
        .round_cnt  (round_w),
        .done       (done[gi])
      );

      assign bus.custom_demux_sel[slice_lo(gi, SEL_W) +: SEL_W] = sel_w;
      assign bus.round_cnt[slice_lo(gi, ROUND_W) +: ROUND_W]    = round_w;
    end
  endgenerate

  // all_done lags the per-channel done terms by one cycle
  always_ff @(posedge clk) begin
    if (rst) all_done_reg <= 1'b0;
    else     all_done_reg <= &done;
  end

  assign bus.all_done = all_done_reg;

endmodule

// File: tb/tb_demux_sel_gen.sv
// Directed bench: three instances (wrap DEPTH=4, wrap DEPTH=3, sat DEPTH=4).
module tb_demux_sel_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  demux_sel_gen_if #(.NUM_CH(4), .SEL_W(2), .ROUND_W(4)) w4_if ();
  demux_sel_gen_if #(.NUM_CH(4), .SEL_W(2), .ROUND_W(4)) w3_if ();
  demux_sel_gen_if #(.NUM_CH(4), .SEL_W(2), .ROUND_W(4)) s4_if ();

  demux_sel_gen #(.NUM_CH(4), .DEPTH(4), .WRAP_MODE(1), .ROUND_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .bus(w4_if.slave));
  demux_sel_gen #(.NUM_CH(4), .DEPTH(3), .WRAP_MODE(1), .ROUND_W(4)) dut_w3 (
    .clk(clk), .rst(rst), .bus(w3_if.slave));
  demux_sel_gen #(.NUM_CH(4), .DEPTH(4), .WRAP_MODE(0), .ROUND_W(4)) dut_s4 (
    .clk(clk), .rst(rst), .bus(s4_if.slave));

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    w4_if.buff_use = '0; w4_if.ch_clr = '0;
    w3_if.buff_use = '0; w3_if.ch_clr = '0;
    s4_if.buff_use = '0; s4_if.ch_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w4_if.buff_use = 4'hF; w3_if.buff_use = 4'hF; s4_if.buff_use = 4'hF;
    w4_if.ch_clr = '0; w3_if.ch_clr = '0; s4_if.ch_clr = '0;
    step(); step();
    total++;
    if ({w4_if.custom_demux_sel, w3_if.custom_demux_sel, s4_if.custom_demux_sel} !== 24'h0) begin
      bad++; $display("FAIL reset_sel got=%h exp=0",
        {w4_if.custom_demux_sel, w3_if.custom_demux_sel, s4_if.custom_demux_sel});
    end
    total++;
    if ({w4_if.round_cnt, w3_if.round_cnt, s4_if.round_cnt} !== 48'h0) begin
      bad++; $display("FAIL reset_round got=%h exp=0",
        {w4_if.round_cnt, w3_if.round_cnt, s4_if.round_cnt});
    end
    total++;
    if ({w4_if.all_done, w3_if.all_done, s4_if.all_done, w4_if.wrap_pulse, s4_if.sat_flag} !== 11'h0) begin
      bad++; $display("FAIL reset_flags got=%h exp=0",
        {w4_if.all_done, w3_if.all_done, s4_if.all_done, w4_if.wrap_pulse, s4_if.sat_flag});
    end
    idle_all();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if ({w4_if.custom_demux_sel, w4_if.round_cnt, w4_if.wrap_pulse, w4_if.all_done,
           s4_if.custom_demux_sel, s4_if.sat_flag} !== 41'h0) begin
        bad++; $display("FAIL idle_outputs cycle=%0d got=%h exp=0", k,
          {w4_if.custom_demux_sel, w4_if.round_cnt, w4_if.wrap_pulse, w4_if.all_done,
           s4_if.custom_demux_sel, s4_if.sat_flag});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_wrap4();
    logic [1:0] exp_sel;
    logic [3:0] exp_pulse;
    w4_if.buff_use = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_sel   = (k == 3) ? 2'd0 : 2'(k + 1);
      exp_pulse = (k == 3) ? 4'b0001 : 4'b0000;
      total++;
      if (w4_if.custom_demux_sel[1:0] !== exp_sel) begin
        bad++; $display("FAIL wrap4_sel step=%0d got=%0d exp=%0d", k, w4_if.custom_demux_sel[1:0], exp_sel);
      end
      total++;
      if (w4_if.wrap_pulse !== exp_pulse) begin
        bad++; $display("FAIL wrap4_pulse step=%0d got=%b exp=%b", k, w4_if.wrap_pulse, exp_pulse);
      end
    end
    w4_if.buff_use = '0;
    step();
    total++;
    if (w4_if.wrap_pulse !== 4'b0000) begin
      bad++; $display("FAIL wrap4_pulse_drop got=%b exp=0000", w4_if.wrap_pulse);
    end
    total++;
    if (w4_if.round_cnt !== 16'h0001) begin
      bad++; $display("FAIL wrap4_round got=%h exp=0001", w4_if.round_cnt);
    end
    total++;
    if (w4_if.custom_demux_sel !== 8'h00) begin
      bad++; $display("FAIL wrap4_others got=%h exp=00", w4_if.custom_demux_sel);
    end
    $display("test_wrap4 done");
  endtask

  task automatic test_depth3();
    logic [1:0] exp_sel;
    logic       exp_pulse;
    int         pulses;
    pulses = 0;
    w3_if.buff_use = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_sel   = 2'((k + 1) % 3);
      exp_pulse = ((k + 1) % 3) == 0;
      if (w3_if.wrap_pulse[2]) pulses++;
      total++;
      if (w3_if.custom_demux_sel[5:4] !== exp_sel) begin
        bad++; $display("FAIL depth3_sel step=%0d got=%0d exp=%0d", k, w3_if.custom_demux_sel[5:4], exp_sel);
      end
      total++;
      if (w3_if.wrap_pulse !== {1'b0, exp_pulse, 2'b00}) begin
        bad++; $display("FAIL depth3_pulse step=%0d got=%b exp=%b", k, w3_if.wrap_pulse, {1'b0, exp_pulse, 2'b00});
      end
    end
    w3_if.buff_use = '0;
    step();
    total++;
    if (pulses != 3) begin
      bad++; $display("FAIL depth3_pulse_count got=%0d exp=3", pulses);
    end
    total++;
    if (w3_if.round_cnt !== 16'h0300) begin
      bad++; $display("FAIL depth3_round got=%h exp=0300", w3_if.round_cnt);
    end
    $display("test_depth3 done");
  endtask

  task automatic test_round_sat();
    // 17 rounds on a 4-bit counter must stick at 15
    w3_if.buff_use = 4'b0001;
    for (int k = 0; k < 51; k++) step();
    w3_if.buff_use = '0;
    step();
    total++;
    if (w3_if.round_cnt[3:0] !== 4'hF) begin
      bad++; $display("FAIL round_saturate got=%0d exp=15", w3_if.round_cnt[3:0]);
    end
    total++;
    if (w3_if.custom_demux_sel[1:0] !== 2'd0) begin
      bad++; $display("FAIL round_saturate_sel got=%0d exp=0", w3_if.custom_demux_sel[1:0]);
    end
    $display("test_round_sat done");
  endtask

  task automatic test_saturate();
    int exp_sel[6]  = '{1, 2, 3, 3, 3, 3};
    int exp_flag[6] = '{0, 0, 0, 1, 1, 1};
    s4_if.buff_use = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (s4_if.custom_demux_sel[3:2] !== 2'(exp_sel[k])) begin
        bad++; $display("FAIL sat_sel step=%0d got=%0d exp=%0d", k, s4_if.custom_demux_sel[3:2], exp_sel[k]);
      end
      total++;
      if (s4_if.sat_flag !== {2'b00, 1'(exp_flag[k]), 1'b0}) begin
        bad++; $display("FAIL sat_flag step=%0d got=%b exp=%b", k, s4_if.sat_flag, {2'b00, 1'(exp_flag[k]), 1'b0});
      end
      total++;
      if (s4_if.wrap_pulse !== 4'b0000) begin
        bad++; $display("FAIL sat_no_pulse step=%0d got=%b exp=0000", k, s4_if.wrap_pulse);
      end
    end
    s4_if.buff_use = '0;
    step();
    total++;
    if ({s4_if.all_done, s4_if.round_cnt} !== 17'h0) begin
      bad++; $display("FAIL sat_round_done got=%h exp=0", {s4_if.all_done, s4_if.round_cnt});
    end
    $display("test_saturate done");
  endtask

  task automatic test_clear_collision();
    // Wrap ch3 once, then bring it to sel=2
    w4_if.buff_use = 4'b1000;
    for (int k = 0; k < 6; k++) step();
    total++;
    if ({w4_if.custom_demux_sel[7:6], w4_if.round_cnt[15:12]} !== 6'b10_0001) begin
      bad++; $display("FAIL clr_setup got sel=%0d round=%0d exp sel=2 round=1",
        w4_if.custom_demux_sel[7:6], w4_if.round_cnt[15:12]);
    end
    w4_if.ch_clr = 4'b1000;
    step();
    w4_if.ch_clr = '0;
    total++;
    if ({w4_if.custom_demux_sel[7:6], w4_if.round_cnt[15:12]} !== 6'b00_0000) begin
      bad++; $display("FAIL clr_collision got sel=%0d round=%0d exp sel=0 round=0",
        w4_if.custom_demux_sel[7:6], w4_if.round_cnt[15:12]);
    end
    step();
    w4_if.buff_use = '0;
    total++;
    if (w4_if.custom_demux_sel[7:6] !== 2'd1) begin
      bad++; $display("FAIL clr_next_enable got=%0d exp=1", w4_if.custom_demux_sel[7:6]);
    end
    total++;
    if ({w4_if.custom_demux_sel[1:0], w4_if.round_cnt[3:0]} !== 6'b00_0001) begin
      bad++; $display("FAIL clr_isolation got sel0=%0d round0=%0d exp sel0=0 round0=1",
        w4_if.custom_demux_sel[1:0], w4_if.round_cnt[3:0]);
    end
    $display("test_clear_collision done");
  endtask

  task automatic test_all_done();
    logic [3:0] mask;
    rst = 1'b1;
    idle_all();
    step();
    rst = 1'b0;
    // Wrap channels one after another: 0, 2, 1, 3
    for (int c = 0; c < 4; c++) begin
      mask = 4'b0001 << ((c == 1) ? 2 : (c == 2) ? 1 : c);
      w4_if.buff_use = mask;
      for (int k = 0; k < 4; k++) step();
      total++;
      if (w4_if.all_done !== 1'b0) begin
        bad++; $display("FAIL all_done_early chan_step=%0d got=%b exp=0", c, w4_if.all_done);
      end
    end
    w4_if.buff_use = '0;
    total++;
    if (w4_if.round_cnt !== 16'h1111) begin
      bad++; $display("FAIL all_done_rounds got=%h exp=1111", w4_if.round_cnt);
    end
    step();
    total++;
    if (w4_if.all_done !== 1'b1) begin
      bad++; $display("FAIL all_done_rise got=%b exp=1", w4_if.all_done);
    end
    w4_if.ch_clr = 4'b0010;
    step();
    w4_if.ch_clr = '0;
    total++;
    if ({w4_if.all_done, w4_if.round_cnt} !== 17'h1_1101) begin
      bad++; $display("FAIL all_done_clr_edge got=%h exp=11101", {w4_if.all_done, w4_if.round_cnt});
    end
    step();
    total++;
    if (w4_if.all_done !== 1'b0) begin
      bad++; $display("FAIL all_done_fall got=%b exp=0", w4_if.all_done);
    end
    // Reset mid-count
    w4_if.buff_use = 4'b0001;
    step(); step();
    w4_if.buff_use = 4'hF;
    rst = 1'b1;
    step();
    total++;
    if ({w4_if.custom_demux_sel, w4_if.round_cnt, w4_if.wrap_pulse, w4_if.all_done} !== 29'h0) begin
      bad++; $display("FAIL reset_midcount got=%h exp=0",
        {w4_if.custom_demux_sel, w4_if.round_cnt, w4_if.wrap_pulse, w4_if.all_done});
    end
    rst = 1'b0;
    w4_if.buff_use = '0;
    step();
    total++;
    if ({w4_if.custom_demux_sel, w4_if.wrap_pulse, w4_if.all_done} !== 13'h0) begin
      bad++; $display("FAIL reset_release got=%h exp=0",
        {w4_if.custom_demux_sel, w4_if.wrap_pulse, w4_if.all_done});
    end
    $display("test_all_done done");
  endtask

  initial begin
    test_reset();
    test_wrap4();
    test_depth3();
    test_round_sat();
    test_saturate();
    test_clear_collision();
    test_all_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
